eth_phy_10g_rx_frame_sync_mlane: RTL and testbench

Multi-lane, parametrised 64b/66b block-lock state machine for 10G/40G-class PCS receive paths. One independent sync-header lock engine per SERDES lane, each with a gearbox-aware header-valid qualifier and its own bitslip control. Adds an aggregate all-lanes lock, lock-loss event pulses and saturating per-lane slip statistics. Sits between the SERDES/gearbox outputs and the descrambler/lane-deskew logic.

---
 rtl/eth_phy_10g_rx_frame_sync_mlane_pkg.sv | 18 +
 rtl/eth_phy_10g_rx_frame_sync_mlane_if.sv | 23 ++
 rtl/eth_phy_10g_rx_frame_sync_lane.sv | 120 ++++++++++++
 rtl/eth_phy_10g_rx_frame_sync_mlane.sv | 68 ++++++
 tb/tb_eth_phy_10g_rx_frame_sync_mlane.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/eth_phy_10g_rx_frame_sync_mlane_pkg.sv
// Shared 10G PCS receive definitions: sync header codes and lane lock states.
package eth_phy_10g_pkg;

    localparam int         HDR_WIDTH = 2;
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic {
        LOCK_SEARCH,
        LOCK_ACQUIRED
    } lock_state_t;

    // Only the two transition codes are legal 64b/66b sync headers.
    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_frame_sync_mlane_if.sv
// SERDES/gearbox side of the multi-lane frame sync: headers in, bitslip requests out.
interface eth_phy_10g_rx_frame_sync_mlane_if #(
    parameter int LANES     = 4,
    parameter int HDR_WIDTH = 2
);

    logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
    logic [LANES-1:0]           serdes_rx_hdr_valid;
    logic [LANES-1:0]           serdes_rx_bitslip;

    modport master (
        output serdes_rx_hdr,
        output serdes_rx_hdr_valid,
        input  serdes_rx_bitslip
    );

    modport slave (
        input  serdes_rx_hdr,
        input  serdes_rx_hdr_valid,
        output serdes_rx_bitslip
    );

endinterface

// File: rtl/eth_phy_10g_rx_frame_sync_lane.sv
// One lane of 64b/66b block lock: window/invalid counters, lock state, bitslip with
// post-slip blanking, lock-loss pulse and a saturating slip counter.
module eth_phy_10g_rx_frame_sync_lane
    import eth_phy_10g_pkg::*;
#(
    parameter int SLIP_COUNT_WIDTH = 3,
    parameter int SH_WINDOW        = 64,
    parameter int SH_INVALID_MAX   = 16,
    parameter int STAT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [HDR_WIDTH-1:0]  hdr,
    input  logic                  hdr_valid,
    input  logic                  enable,
    input  logic                  stat_clear,
    output logic                  bitslip,
    output logic                  block_lock,
    output logic                  lock_lost,
    output logic [STAT_WIDTH-1:0] slip_count
);

    localparam int SH_CNT_W  = $clog2(SH_WINDOW);
    localparam int INV_CNT_W = $clog2(SH_INVALID_MAX);

    localparam logic [SH_CNT_W-1:0]         SH_LAST  = SH_CNT_W'(SH_WINDOW - 1);
    localparam logic [INV_CNT_W-1:0]        INV_LAST = INV_CNT_W'(SH_INVALID_MAX - 1);
    localparam logic [SH_CNT_W-1:0]         SH_ONE   = SH_CNT_W'(1);
    localparam logic [INV_CNT_W-1:0]        INV_ONE  = INV_CNT_W'(1);
    localparam logic [SLIP_COUNT_WIDTH-1:0] BLK_ONE  = SLIP_COUNT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0]       STAT_ONE = STAT_WIDTH'(1);

    lock_state_t                 state_q, state_d;
    logic [SH_CNT_W-1:0]         sh_cnt_q, sh_cnt_d;
    logic [INV_CNT_W-1:0]        inv_cnt_q, inv_cnt_d;
    logic [SLIP_COUNT_WIDTH-1:0] blank_cnt_q, blank_cnt_d;
    logic                        bitslip_q, slip_d;
    logic                        lock_lost_q, lost_d;
    logic [STAT_WIDTH-1:0]       slip_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOCK_SEARCH;
            sh_cnt_q    <= '0;
            inv_cnt_q   <= '0;
            blank_cnt_q <= '0;
            bitslip_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            inv_cnt_q   <= inv_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            bitslip_q   <= slip_d;
            lock_lost_q <= lost_d;
        end
    end

    // A clear that coincides with a slip keeps that slip, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_cnt_q <= '0;
        end else if (stat_clear) begin
            slip_cnt_q <= slip_d ? STAT_ONE : '0;
        end else if (slip_d && (slip_cnt_q != '1)) begin
            slip_cnt_q <= slip_cnt_q + STAT_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        inv_cnt_d   = inv_cnt_q;
        blank_cnt_d = blank_cnt_q;
        slip_d      = 1'b0;
        lost_d      = 1'b0;

        if (!enable) begin
            state_d     = LOCK_SEARCH;
            sh_cnt_d    = '0;
            inv_cnt_d   = '0;
            blank_cnt_d = '0;
            lost_d      = (state_q == LOCK_ACQUIRED);
        end else if (blank_cnt_q != '0) begin
            // Blanking runs on clocks, not headers, so gearbox gaps do not stretch it.
            blank_cnt_d = blank_cnt_q - BLK_ONE;
        end else if (hdr_valid) begin
            if (hdr_is_valid(hdr)) begin
                if (sh_cnt_q == SH_LAST) begin
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                    if (inv_cnt_q == '0) begin
                        state_d = LOCK_ACQUIRED;
                    end
                end else begin
                    sh_cnt_d = sh_cnt_q + SH_ONE;
                end
            end else if ((state_q == LOCK_SEARCH) || (inv_cnt_q == INV_LAST)) begin
                state_d     = LOCK_SEARCH;
                sh_cnt_d    = '0;
                inv_cnt_d   = '0;
                blank_cnt_d = '1;
                slip_d      = 1'b1;
                lost_d      = (state_q == LOCK_ACQUIRED);
            end else if (sh_cnt_q == SH_LAST) begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
            end else begin
                sh_cnt_d  = sh_cnt_q + SH_ONE;
                inv_cnt_d = inv_cnt_q + INV_ONE;
            end
        end
    end

    assign bitslip    = bitslip_q;
    assign block_lock = (state_q == LOCK_ACQUIRED);
    assign lock_lost  = lock_lost_q;
    assign slip_count = slip_cnt_q;

endmodule

// File: rtl/eth_phy_10g_rx_frame_sync_mlane.sv
// Multi-lane 64b/66b block lock: one independent lock engine per SERDES lane plus a
// registered all-enabled-lanes-locked indication.
module eth_phy_10g_rx_frame_sync_mlane #(
    parameter int LANES            = 4,
    parameter int HDR_WIDTH        = 2,
    parameter int SLIP_COUNT_WIDTH = 3,
    parameter int SH_WINDOW        = 64,
    parameter int SH_INVALID_MAX   = 16,
    parameter int STAT_WIDTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    eth_phy_10g_rx_frame_sync_mlane_if.slave serdes,
    input  logic [LANES-1:0]               cfg_lane_enable,
    input  logic                           stat_clear,
    output logic [LANES-1:0]               rx_block_lock,
    output logic                           rx_block_lock_all,
    output logic [LANES-1:0]               rx_lock_lost,
    output logic [LANES*STAT_WIDTH-1:0]    rx_slip_count
);

    if (HDR_WIDTH != eth_phy_10g_pkg::HDR_WIDTH) begin : g_bad_hdr_width
        $error("HDR_WIDTH must be 2");
    end
    if ((LANES < 1) || (LANES > 16)) begin : g_bad_lanes
        $error("LANES must be in 1..16");
    end
    if ((SH_WINDOW < 4) || ((SH_WINDOW & (SH_WINDOW - 1)) != 0)) begin : g_bad_window
        $error("SH_WINDOW must be a power of two and at least 4");
    end
    if ((SH_INVALID_MAX < 2) || (SH_INVALID_MAX > SH_WINDOW)) begin : g_bad_inv_max
        $error("SH_INVALID_MAX must be in 2..SH_WINDOW");
    end

    logic [LANES-1:0] bitslip;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        eth_phy_10g_rx_frame_sync_lane #(
            .SLIP_COUNT_WIDTH (SLIP_COUNT_WIDTH),
            .SH_WINDOW        (SH_WINDOW),
            .SH_INVALID_MAX   (SH_INVALID_MAX),
            .STAT_WIDTH       (STAT_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .hdr        (serdes.serdes_rx_hdr[i*HDR_WIDTH +: HDR_WIDTH]),
            .hdr_valid  (serdes.serdes_rx_hdr_valid[i]),
            .enable     (cfg_lane_enable[i]),
            .stat_clear (stat_clear),
            .bitslip    (bitslip[i]),
            .block_lock (rx_block_lock[i]),
            .lock_lost  (rx_lock_lost[i]),
            .slip_count (rx_slip_count[i*STAT_WIDTH +: STAT_WIDTH])
        );
    end

    assign serdes.serdes_rx_bitslip = bitslip;

    // Disabled lanes are masked out; with nothing enabled there is nothing to be locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_block_lock_all <= 1'b0;
        end else begin
            rx_block_lock_all <= (|cfg_lane_enable) && (&(rx_block_lock | ~cfg_lane_enable));
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_frame_sync_mlane.sv
// Directed bench for the multi-lane frame sync: a vector table for lock/slip/window
// behaviour plus hand-written sequences for gaps, aggregate lock, reset and saturation.
module tb_eth_phy_10g_rx_frame_sync_mlane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_lane_enable;
    logic        stat_clear;
    logic [3:0]  rx_block_lock;
    logic        rx_block_lock_all;
    logic [3:0]  rx_lock_lost;
    logic [31:0] rx_slip_count;

    int checks = 0;
    int passes = 0;

    eth_phy_10g_rx_frame_sync_mlane_if #(.LANES(4), .HDR_WIDTH(2)) serdes_if ();

    eth_phy_10g_rx_frame_sync_mlane #(
        .LANES            (4),
        .HDR_WIDTH        (2),
        .SLIP_COUNT_WIDTH (3),
        .SH_WINDOW        (64),
        .SH_INVALID_MAX   (16),
        .STAT_WIDTH       (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .serdes            (serdes_if),
        .cfg_lane_enable   (cfg_lane_enable),
        .stat_clear        (stat_clear),
        .rx_block_lock     (rx_block_lock),
        .rx_block_lock_all (rx_block_lock_all),
        .rx_lock_lost      (rx_lock_lost),
        .rx_slip_count     (rx_slip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  hdr;
        logic [3:0]  vld;
        logic [3:0]  en;
        int          cycles;
        logic [3:0]  e_slip;
        logic [3:0]  e_lock;
        logic [3:0]  e_lost;
        logic        e_all;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] hdr, input logic [3:0] vld,
                                  input logic [3:0] en, input logic clr);
        serdes_if.serdes_rx_hdr       = hdr;
        serdes_if.serdes_rx_hdr_valid = vld;
        cfg_lane_enable               = en;
        stat_clear                    = clr;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_all_outputs(input string name, input logic [3:0] e_slip,
                                     input logic [3:0] e_lock, input logic [3:0] e_lost,
                                     input logic e_all, input logic [31:0] e_cnt);
        check_output({name, " bitslip"},   32'(serdes_if.serdes_rx_bitslip), 32'(e_slip));
        check_output({name, " lock"},      32'(rx_block_lock),               32'(e_lock));
        check_output({name, " lock_lost"}, 32'(rx_lock_lost),                32'(e_lost));
        check_output({name, " lock_all"},  32'(rx_block_lock_all),           32'(e_all));
        check_output({name, " slip_cnt"},  rx_slip_count,                    e_cnt);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  pulses;
        logic prev_slip;
        logic consec;
        logic slip_seen;

        // hdr 55: all lanes 01; 51: lane1 00; 45: lane2 00
        vecs[0]  = '{"lane0_63_hdrs",    8'h55, 4'h1, 4'h1, 63, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{"lane0_64th_hdr",   8'h55, 4'h1, 4'h1,  1, 4'h0, 4'h1, 4'h0, 1'b0, 32'h0000_0000};
        vecs[2]  = '{"lane0_all_reg",    8'h55, 4'h1, 4'h1,  1, 4'h0, 4'h1, 4'h0, 1'b1, 32'h0000_0000};
        vecs[3]  = '{"lane1_slip",       8'h51, 4'h3, 4'h3,  1, 4'h2, 4'h1, 4'h0, 1'b0, 32'h0000_0100};
        vecs[4]  = '{"lane1_blank1",     8'h51, 4'h3, 4'h3,  1, 4'h0, 4'h1, 4'h0, 1'b0, 32'h0000_0100};
        vecs[5]  = '{"lane1_blank7",     8'h51, 4'h3, 4'h3,  6, 4'h0, 4'h1, 4'h0, 1'b0, 32'h0000_0100};
        vecs[6]  = '{"lane1_reslip",     8'h51, 4'h3, 4'h3,  1, 4'h2, 4'h1, 4'h0, 1'b0, 32'h0000_0200};
        vecs[7]  = '{"lane1_valid",      8'h55, 4'h3, 4'h3,  8, 4'h0, 4'h1, 4'h0, 1'b0, 32'h0000_0200};
        vecs[8]  = '{"lane1_disable",    8'h55, 4'h1, 4'h1,  1, 4'h0, 4'h1, 4'h0, 1'b1, 32'h0000_0200};
        vecs[9]  = '{"lane2_lock",       8'h55, 4'h5, 4'h5, 64, 4'h0, 4'h5, 4'h0, 1'b0, 32'h0000_0200};
        vecs[10] = '{"lane2_all_reg",    8'h55, 4'h5, 4'h5,  1, 4'h0, 4'h5, 4'h0, 1'b1, 32'h0000_0200};
        vecs[11] = '{"lane2_15_invalid", 8'h45, 4'h5, 4'h5, 15, 4'h0, 4'h5, 4'h0, 1'b1, 32'h0000_0200};
        vecs[12] = '{"lane2_window_end", 8'h55, 4'h5, 4'h5, 48, 4'h0, 4'h5, 4'h0, 1'b1, 32'h0000_0200};
        vecs[13] = '{"lane2_15_again",   8'h45, 4'h5, 4'h5, 15, 4'h0, 4'h5, 4'h0, 1'b1, 32'h0000_0200};
        vecs[14] = '{"lane2_16th_inv",   8'h45, 4'h5, 4'h5,  1, 4'h4, 4'h1, 4'h4, 1'b1, 32'h0001_0200};
        vecs[15] = '{"lane2_after_loss", 8'h55, 4'h5, 4'h5,  1, 4'h0, 4'h1, 4'h0, 1'b0, 32'h0001_0200};

        rst_n = 1'b0;
        apply_stimulus(8'h00, 4'h0, 4'h0, 1'b0);
        repeat (3) tick();
        check_all_outputs("reset", 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].hdr, vecs[i].vld, vecs[i].en, 1'b0);
            repeat (vecs[i].cycles) tick();
            check_all_outputs(vecs[i].name, vecs[i].e_slip, vecs[i].e_lock,
                              vecs[i].e_lost, vecs[i].e_all, vecs[i].e_cnt);
        end

        // Lane3 qualified every other clock, with illegal headers on the gap cycles
        slip_seen = 1'b0;
        for (int k = 0; k < 128; k++) begin
            if (k % 2 == 0) apply_stimulus(8'h45, 4'hB, 4'hB, 1'b0);
            else            apply_stimulus(8'hC5, 4'h3, 4'hB, 1'b0);
            tick();
            slip_seen = slip_seen | (|serdes_if.serdes_rx_bitslip);
            if (k == 125) check_output("gap_lock_63", 32'(rx_block_lock), 32'h3);
            if (k == 126) check_output("gap_lock_64", 32'(rx_block_lock), 32'hB);
            if (k == 127) check_output("gap_lock_all", 32'(rx_block_lock_all), 32'h1);
        end
        check_output("gap_no_slip", 32'(slip_seen), 32'h0);

        apply_stimulus(8'h55, 4'hF, 4'hF, 1'b0);
        tick();
        check_output("enable2_all_drop", 32'(rx_block_lock_all), 32'h0);
        check_output("enable2_lock", 32'(rx_block_lock), 32'hB);

        apply_stimulus(8'h55, 4'hF, 4'hE, 1'b0);
        tick();
        check_output("disable0_lost", 32'(rx_lock_lost), 32'h1);
        check_output("disable0_lock", 32'(rx_block_lock), 32'hA);
        check_output("disable0_cnt", rx_slip_count, 32'h0001_0200);
        tick();
        check_output("disable0_lost_once", 32'(rx_lock_lost), 32'h0);

        #2;
        rst_n = 1'b0;
        #1;
        check_all_outputs("async_reset", 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;

        // Continuous invalid headers on lane0: one slip every 8 clocks
        apply_stimulus(8'h00, 4'h1, 4'h1, 1'b0);
        pulses    = 0;
        prev_slip = 1'b0;
        consec    = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            tick();
            if (serdes_if.serdes_rx_bitslip[0]) pulses++;
            if (serdes_if.serdes_rx_bitslip[0] && prev_slip) consec = 1'b1;
            prev_slip = serdes_if.serdes_rx_bitslip[0];
        end
        check_output("sat_pulses", 32'(pulses), 32'd300);
        check_output("sat_no_consec", 32'(consec), 32'h0);
        check_output("sat_count", rx_slip_count, 32'h0000_00FF);
        check_output("sat_no_lost", 32'(rx_lock_lost), 32'h0);

        apply_stimulus(8'h00, 4'h1, 4'h1, 1'b1);
        tick();
        check_output("clear_with_slip_pulse", 32'(serdes_if.serdes_rx_bitslip), 32'h1);
        check_output("clear_with_slip_cnt", rx_slip_count, 32'h0000_0001);
        tick();
        check_output("clear_alone_cnt", rx_slip_count, 32'h0000_0000);
        apply_stimulus(8'h00, 4'h1, 4'h1, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
